// File: rtl/poly_shift_pkg.sv
// rtl/poly_shift_pkg.sv - shared constants and FSM encoding for the Poly_shift stream scheduler
package poly_shift_pkg;

    // Coefficients per polynomial stream and the matching address width
    localparam int N       = 512;
    localparam int ADDR_W  = 9;

    // Idle guard after the last output beat; covers the Poly_shift_rst pulse
    localparam int GAP_CYC = 8;

    // Allowed silence between output beats when the watchdog is built in
    localparam int TMO_CYC = 64;

    // Shift_mod encodings: 1 selects q=31, 0 selects q=125
    localparam logic Q_SHIFT31  = 1'b1;
    localparam logic Q_SHIFT125 = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter, combinational; pointer held by the caller
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);

    // A sole requester wins outright; on a tie the one not served last wins
    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/poly_shift_sched.sv
// rtl/poly_shift_sched.sv - Poly_shift stream scheduler; optional watchdog via POLY_SHIFT_SCHED_TIMEOUT_EN
module poly_shift_sched
    import poly_shift_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        cfg_shift,
    input  logic [1:0]        cfg_add,
    output logic [1:0]        gnt,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              din_flag,
    output logic              shift_mod,
    output logic              add_mod,
    input  logic              dout_flag,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [1:0]        done,
    output logic              busy,
    output logic              err
`ifdef POLY_SHIFT_SCHED_TIMEOUT_EN
    ,
    output logic              tmo
`endif
);

    localparam int GAP_W = $clog2(GAP_CYC);

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic [1:0]          win_q, win_d;
    logic [ADDR_W-1:0]   rd_q, rd_d;
    logic [ADDR_W:0]     out_cnt_q, out_cnt_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                shift_q, shift_d;
    logic                add_q, add_d;
    logic                err_q, err_d;

    logic [1:0]          arb_win;
    logic                in_stream;
    logic                cnt_full;
    logic                beat_ok;
    logic                beat_stray;

`ifdef POLY_SHIFT_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC);

    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                wd_run;
    logic                wd_expire;
`endif

    rr_arb2 u_arb (
        .req  (req),
        .last (last_q),
        .win  (arb_win)
    );

    assign in_stream  = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign cnt_full   = (out_cnt_q == (ADDR_W+1)'(N));
    assign beat_ok    = dout_flag && in_stream && !cnt_full;
    assign beat_stray = dout_flag && ((state_q == S_IDLE) || (state_q == S_GAP)
                                      || (in_stream && cnt_full));

`ifdef POLY_SHIFT_SCHED_TIMEOUT_EN
    // Watchdog arms once the first beat is back, so pipeline latency never trips it
    always_comb begin
        wd_run    = ((state_q == S_ISSUE) && (out_cnt_q != '0)) || (state_q == S_DRAIN);
        wd_expire = wd_run && !dout_flag && (tmo_cnt_q == TMO_W'(TMO_CYC - 1));
        tmo_cnt_d = (wd_run && !dout_flag) ? tmo_cnt_q + 1'b1 : '0;
    end

    assign tmo = wd_expire;
`endif

    // Next-state: sequencing, address generation, beat counting and error capture
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        win_d     = win_q;
        rd_d      = rd_q;
        out_cnt_d = out_cnt_q;
        gap_d     = gap_q;
        shift_d   = shift_q;
        add_d     = add_q;
        err_d     = err_q | beat_stray;

        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    // Config is captured on entry so it is already stable in GRANT
                    state_d = S_GRANT;
                    win_d   = arb_win;
                    shift_d = arb_win[1] ? cfg_shift[1] : cfg_shift[0];
                    add_d   = arb_win[1] ? cfg_add[1]   : cfg_add[0];
                end
            end
            S_GRANT: begin
                rd_d      = '0;
                out_cnt_d = '0;
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                // Wraps to zero after N-1, leaving rd_addr parked at 0
                rd_d = rd_q + 1'b1;
                if (rd_q == ADDR_W'(N - 1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_full) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                last_d  = win_q[1];
                gap_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (beat_ok) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end

`ifdef POLY_SHIFT_SCHED_TIMEOUT_EN
        if (wd_expire) begin
            err_d   = 1'b1;
            rd_d    = '0;
            state_d = S_DONE;
        end
`endif
    end

    // State register; reset returns straight to IDLE with every output cleared
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;
            win_q     <= 2'b00;
            rd_q      <= '0;
            out_cnt_q <= '0;
            gap_q     <= '0;
            shift_q   <= Q_SHIFT125;
            add_q     <= 1'b0;
            err_q     <= 1'b0;
`ifdef POLY_SHIFT_SCHED_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            win_q     <= win_d;
            rd_q      <= rd_d;
            out_cnt_q <= out_cnt_d;
            gap_q     <= gap_d;
            shift_q   <= shift_d;
            add_q     <= add_d;
            err_q     <= err_d;
`ifdef POLY_SHIFT_SCHED_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
`endif
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        gnt       = ((state_q == S_GRANT) || in_stream) ? win_q : 2'b00;
        done      = (state_q == S_DONE) ? win_q : 2'b00;
        rd_addr   = rd_q;
        din_flag  = (state_q == S_ISSUE);
        shift_mod = shift_q;
        add_mod   = add_q;
        wr_en     = beat_ok;
        wr_addr   = out_cnt_q[ADDR_W-1:0];
        busy      = (state_q != S_IDLE);
        err       = err_q;
    end

endmodule

// File: tb/tb_poly_shift_sched.sv
// tb/tb_poly_shift_sched.sv - directed self-checking bench for poly_shift_sched
module tb_poly_shift_sched;
    import poly_shift_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req;
    logic [1:0]        cfg_shift;
    logic [1:0]        cfg_add;
    logic [1:0]        gnt;
    logic [ADDR_W-1:0] rd_addr;
    logic              din_flag;
    logic              shift_mod;
    logic              add_mod;
    logic              dout_flag;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        done;
    logic              busy;
    logic              err;
`ifdef POLY_SHIFT_SCHED_TIMEOUT_EN
    logic              tmo;
`endif

    poly_shift_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .cfg_shift (cfg_shift),
        .cfg_add   (cfg_add),
        .gnt       (gnt),
        .rd_addr   (rd_addr),
        .din_flag  (din_flag),
        .shift_mod (shift_mod),
        .add_mod   (add_mod),
        .dout_flag (dout_flag),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .done      (done),
        .busy      (busy),
        .err       (err)
`ifdef POLY_SHIFT_SCHED_TIMEOUT_EN
        ,
        .tmo       (tmo)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Poly_shift stand-in: dout_flag is din_flag delayed 7 cycles
    logic [7:0] pipe = '0;
    int         emitted;
    int         beat_limit;
    logic       inj = 1'b0;
    logic [1:0] drop_mask;

    int         din_cnt, din_runs, rd_bad, wr_cnt, wr_bad, wr_idx;
    int         done0, done1, done_first, t_done0, t_last_beat;
    int         n_grants, shift_chg, t_shift;
    int         t_grant [4];
    logic [1:0] g_val [4];
    logic       g_shift [4];
    logic       g_add [4];
    logic [1:0] prev_gnt;
    logic       prev_shift, prev_din;

    task automatic clear_stats();
        din_cnt = 0; din_runs = 0; rd_bad = 0; wr_cnt = 0; wr_bad = 0; wr_idx = 0;
        done0 = 0; done1 = 0; done_first = -1; t_done0 = 0; t_last_beat = 0;
        n_grants = 0; shift_chg = 0; t_shift = 0;
        emitted = 0; beat_limit = 1 << 30;
        prev_gnt = gnt; prev_shift = shift_mod; prev_din = din_flag;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        pipe = {pipe[6:0], din_flag};
        dout_flag = 1'b0;
        if (pipe[7] && emitted < beat_limit) begin
            dout_flag = 1'b1;
            emitted++;
        end
        if (inj) begin
            dout_flag = 1'b1;
            inj = 1'b0;
        end
        #1;
        if (gnt !== 2'b00 && prev_gnt === 2'b00 && n_grants < 4) begin
            g_val[n_grants] = gnt; g_shift[n_grants] = shift_mod; g_add[n_grants] = add_mod;
            t_grant[n_grants] = cyc; n_grants++; wr_idx = 0;
        end
        prev_gnt = gnt;
        if (shift_mod !== prev_shift) begin shift_chg++; t_shift = cyc; end
        prev_shift = shift_mod;
        if (din_flag) begin
            if (int'(rd_addr) != din_cnt % N) rd_bad++;
            if (!prev_din) din_runs++;
            din_cnt++;
        end
        prev_din = din_flag;
        if (wr_en) begin
            if (int'(wr_addr) != wr_idx) wr_bad++;
            if (wr_idx == 300) t_last_beat = cyc;
            wr_idx++; wr_cnt++;
        end
        if (done !== 2'b00 && done0 + done1 == 0) done_first = done[0] ? 0 : 1;
        if (done[0]) begin done0++; t_done0 = cyc; if (drop_mask[0]) req[0] = 1'b0; end
        if (done[1]) begin done1++; if (drop_mask[1]) req[1] = 1'b0; end
    endtask

    // Reset held long enough to flush the stand-in pipeline, then the guard gap
    task automatic do_reset();
        rst = 1'b1; req = 2'b00;
        repeat (10) tick();
        rst = 1'b0;
        repeat (GAP_CYC) tick();
    endtask

    task automatic run_stream(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done0 + done1 >= target && !busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({gnt, done} !== 4'b0000) begin failures++; $display("FAIL reset_gnt_done: got %b expected 0000", {gnt, done}); end
        checks++; if ({busy, din_flag, wr_en} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected 000", {busy, din_flag, wr_en}); end
        checks++; if (rd_addr !== '0) begin failures++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
        checks++; if (wr_addr !== '0) begin failures++; $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
        checks++; if ({shift_mod, add_mod, err} !== 3'b000) begin failures++; $display("FAIL reset_cfg_err: got %b expected 000", {shift_mod, add_mod, err}); end
`ifdef POLY_SHIFT_SCHED_TIMEOUT_EN
        checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL reset_tmo: got %b expected 0", tmo); end
`endif
    endtask

    task automatic test_single();
        bit ok;
        clear_stats();
        cfg_shift = 2'b01; cfg_add = 2'b00; drop_mask = 2'b01; req = 2'b01;
        run_stream(1, 2000, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_complete: got %0d expected 1", ok); end
        checks++; if (din_cnt !== N || din_runs !== 1) begin failures++; $display("FAIL single_din: got cnt=%0d runs=%0d expected cnt=%0d runs=1", din_cnt, din_runs, N); end
        checks++; if (rd_bad !== 0) begin failures++; $display("FAIL single_rd_addr_seq: got %0d bad expected 0", rd_bad); end
        checks++; if (wr_cnt !== N || wr_bad !== 0) begin failures++; $display("FAIL single_wr: got cnt=%0d bad=%0d expected cnt=%0d bad=0", wr_cnt, wr_bad, N); end
        checks++; if (done0 !== 1 || done1 !== 0) begin failures++; $display("FAIL single_done: got %0d/%0d expected 1/0", done0, done1); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL single_err: got %b expected 0", err); end
        checks++; if (n_grants !== 1 || g_val[0] !== 2'b01) begin failures++; $display("FAIL single_gnt: got n=%0d g=%b expected n=1 g=01", n_grants, g_val[0]); end
        checks++; if (g_shift[0] !== 1'b1 || g_add[0] !== 1'b0) begin failures++; $display("FAIL single_cfg: got shift=%b add=%b expected 1/0", g_shift[0], g_add[0]); end
        checks++; if (t_done0 - t_grant[0] !== N + 9) begin failures++; $display("FAIL single_latency: got %0d expected %0d", t_done0 - t_grant[0], N + 9); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        clear_stats();
        cfg_shift = 2'b01; cfg_add = 2'b10; drop_mask = 2'b10; req = 2'b11;
        run_stream(2, 3000, ok);
        req = 2'b00;
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL b2b_complete: got %0d expected 1", ok); end
        checks++; if (n_grants !== 2 || g_val[0] !== 2'b01 || g_val[1] !== 2'b10) begin failures++; $display("FAIL b2b_gnt_order: got n=%0d %b,%b expected 2 01,10", n_grants, g_val[0], g_val[1]); end
        checks++; if (done_first !== 0 || done0 !== 1 || done1 !== 1) begin failures++; $display("FAIL b2b_done: got first=%0d %0d/%0d expected 0 1/1", done_first, done0, done1); end
        checks++; if (g_shift[0] !== 1'b1 || g_shift[1] !== 1'b0 || g_add[0] !== 1'b0 || g_add[1] !== 1'b1) begin failures++; $display("FAIL b2b_cfg: got %b%b %b%b expected 10 01", g_shift[0], g_shift[1], g_add[0], g_add[1]); end
        checks++; if (shift_chg !== 2 || t_shift !== t_grant[1]) begin failures++; $display("FAIL b2b_shift_switch: got chg=%0d at=%0d expected 2 at=%0d", shift_chg, t_shift, t_grant[1]); end
        checks++; if (t_grant[1] - t_done0 !== GAP_CYC + 2) begin failures++; $display("FAIL b2b_gap: got %0d expected %0d", t_grant[1] - t_done0, GAP_CYC + 2); end
        checks++; if (din_cnt !== 2 * N || wr_cnt !== 2 * N || rd_bad !== 0 || wr_bad !== 0) begin failures++; $display("FAIL b2b_beats: got din=%0d wr=%0d rbad=%0d wbad=%0d expected %0d", din_cnt, wr_cnt, rd_bad, wr_bad, 2 * N); end
        tick();
        checks++; if (busy !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL b2b_idle: got busy=%b err=%b expected 0/0", busy, err); end
    endtask

    task automatic test_extra_beat();
        int  n = 0;
        bit  fin = 1'b0;
        bit  injected = 1'b0;
        logic err_before = 1'bx, extra_wr = 1'bx;
        logic [1:0] extra_done = 2'bxx;
        do_reset();
        clear_stats();
        drop_mask = 2'b01; req = 2'b01;
        while (n < 2000 && !fin) begin
            if (wr_cnt == N && !injected) begin
                err_before = err; inj = 1'b1; injected = 1'b1;
                tick();
                extra_wr = wr_en; extra_done = done;
            end else begin
                tick();
            end
            n++;
            if (done0 >= 1 && !busy) fin = 1'b1;
        end
        checks++; if (fin !== 1'b1 || injected !== 1'b1) begin failures++; $display("FAIL extra_complete: got fin=%0d inj=%0d expected 1/1", fin, injected); end
        checks++; if (err_before !== 1'b0) begin failures++; $display("FAIL extra_err_before: got %b expected 0", err_before); end
        checks++; if (extra_wr !== 1'b0 || extra_done !== 2'b00) begin failures++; $display("FAIL extra_wr_en: got wr=%b done=%b expected 0/00", extra_wr, extra_done); end
        checks++; if (err !== 1'b1 || wr_cnt !== N || done0 !== 1) begin failures++; $display("FAIL extra_err: got err=%b wr=%0d done=%0d expected 1/%0d/1", err, wr_cnt, done0, N); end
    endtask

    task automatic test_rst_mid();
        int n = 0;
        bit ok;
        do_reset();
        clear_stats();
        drop_mask = 2'b01; req = 2'b01;
        while (!(din_flag === 1'b1 && rd_addr === ADDR_W'(200)) && n < 400) begin tick(); n++; end
        checks++; if (rd_addr !== ADDR_W'(200)) begin failures++; $display("FAIL rst_reach_200: got %0d expected 200", rd_addr); end
        rst = 1'b1; req = 2'b00;
        tick();
        checks++; if ({busy, din_flag, gnt} !== 4'b0000 || rd_addr !== '0) begin failures++; $display("FAIL rst_immediate: got %b rd=%0d expected 0000 rd=0", {busy, din_flag, gnt}, rd_addr); end
        rst = 1'b0;
        repeat (GAP_CYC) tick();
        checks++; if (err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rst_inflight_err: got err=%b busy=%b expected 1/0", err, busy); end
        clear_stats();
        req = 2'b01;
        tick();
        checks++; if (gnt !== 2'b01 || rd_addr !== '0 || din_flag !== 1'b0) begin failures++; $display("FAIL rst_regrant: got gnt=%b rd=%0d din=%b expected 01/0/0", gnt, rd_addr, din_flag); end
        tick();
        tick();
        checks++; if (din_flag !== 1'b1 || rd_addr !== ADDR_W'(1)) begin failures++; $display("FAIL rst_restart_addr: got din=%b rd=%0d expected 1/1", din_flag, rd_addr); end
        run_stream(1, 2000, ok);
        checks++; if (ok !== 1'b1 || din_cnt !== N || rd_bad !== 0 || done0 !== 1) begin failures++; $display("FAIL rst_restart_stream: got ok=%0d din=%0d bad=%0d done=%0d expected 1/%0d/0/1", ok, din_cnt, rd_bad, done0, N); end
    endtask

    task automatic test_idle_beat();
        do_reset();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL idle_err_clear: got %b expected 0", err); end
        inj = 1'b1;
        tick();
        checks++; if (wr_en !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL idle_beat_wr: got wr=%b busy=%b expected 0/0", wr_en, busy); end
        tick();
        checks++; if (err !== 1'b1 || busy !== 1'b0 || gnt !== 2'b00) begin failures++; $display("FAIL idle_beat_err: got err=%b busy=%b gnt=%b expected 1/0/00", err, busy, gnt); end
    endtask

`ifdef POLY_SHIFT_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        int tmo_n = 0;
        int t_tmo = 0;
        bit fin = 1'b0;
        logic err_after = 1'bx;
        logic [1:0] done_after = 2'bxx;
        do_reset();
        clear_stats();
        beat_limit = 301; drop_mask = 2'b01; req = 2'b01;
        while (n < 2000 && !fin) begin
            tick(); n++;
            if (tmo === 1'b1) begin
                tmo_n++; t_tmo = cyc;
                tick(); n++;
                err_after = err; done_after = done;
            end
            if (done0 >= 1 && !busy) fin = 1'b1;
        end
        checks++; if (fin !== 1'b1 || tmo_n !== 1) begin failures++; $display("FAIL tmo_complete: got fin=%0d tmo=%0d expected 1/1", fin, tmo_n); end
        checks++; if (t_tmo - t_last_beat !== TMO_CYC) begin failures++; $display("FAIL tmo_latency: got %0d expected %0d", t_tmo - t_last_beat, TMO_CYC); end
        checks++; if (err_after !== 1'b1 || done_after !== 2'b01) begin failures++; $display("FAIL tmo_err_done: got err=%b done=%b expected 1/01", err_after, done_after); end
        checks++; if (wr_cnt !== 301 || busy !== 1'b0) begin failures++; $display("FAIL tmo_beats: got wr=%0d busy=%b expected 301/0", wr_cnt, busy); end
        beat_limit = 1 << 30;
    endtask
`endif

    initial begin
        rst = 1'b1; req = 2'b00; cfg_shift = 2'b00; cfg_add = 2'b00;
        dout_flag = 1'b0; drop_mask = 2'b00;
        emitted = 0; beat_limit = 1 << 30;
        test_reset();
        test_single();
        test_back_to_back();
        test_extra_beat();
        test_rst_mid();
        test_idle_beat();
`ifdef POLY_SHIFT_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
